// File: rtl/pit_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pit_pkg
// Desc     : Shared types and constants for the Pending Interest Table.
// Revision : 1.0
// ============================================================================
package pit_pkg;

  localparam int PREFIX_W = 64;
  localparam int LEN_W    = 6;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_I_LOOKUP = 3'd1,
    ST_I_UPDATE = 3'd2,
    ST_D_LOOKUP = 3'd3,
    ST_D_RESP   = 3'd4,
    ST_RECEIVE  = 3'd5
  } pit_state_t;

  // Match key of one entry; the face mask is stored alongside in the top.
  typedef struct packed {
    logic                valid;
    logic [PREFIX_W-1:0] prefix;
    logic [LEN_W-1:0]    len;
  } pit_entry_t;

endpackage
`default_nettype wire

// File: rtl/pit_match.sv
`default_nettype none
// ============================================================================
// Module   : pit_match
// Desc     : Parallel key compare over all PIT entries with lowest-index
//            priority encoding of the hit and of the first free slot.
// Revision : 1.0
// ============================================================================
module pit_match
  import pit_pkg::*;
#(
  parameter  int ENTRIES = 16,
  localparam int IDX_W   = $clog2(ENTRIES)
)(
  input  logic [PREFIX_W-1:0] prefix,
  input  logic [LEN_W-1:0]    len,
  input  pit_entry_t          entries [ENTRIES],
  output logic                hit,
  output logic [IDX_W-1:0]    hit_idx,
  output logic                free,
  output logic [IDX_W-1:0]    free_idx
);

  logic [ENTRIES-1:0] w_hit_vec;
  logic [ENTRIES-1:0] w_free_vec;

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cmp
    assign w_hit_vec[gi]  = entries[gi].valid && (entries[gi].prefix == prefix) &&
                            (entries[gi].len == len);
    assign w_free_vec[gi] = !entries[gi].valid;
  end

  always_comb begin
    hit      = |w_hit_vec;
    free     = |w_free_vec;
    hit_idx  = '0;
    free_idx = '0;
    // Descending scan so the lowest matching index is the one left standing.
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (w_hit_vec[i])  hit_idx  = IDX_W'(i);
      if (w_free_vec[i]) free_idx = IDX_W'(i);
    end
  end

endmodule
`default_nettype wire

// File: rtl/pit_table.sv
`default_nettype none
// ============================================================================
// Module   : pit_table
// Desc     : Pending Interest Table: interest aggregation and FIB forwarding,
//            data prefix check and payload fan-out to requesting faces.
//            Define PIT_TIMEOUT_EN for per-entry ageing and pit_expire.
// Revision : 1.0
// ============================================================================
module pit_table
  import pit_pkg::*;
#(
  parameter int ENTRIES    = 16,
  parameter int NUM_FACES  = 4,
  parameter int DATA_BYTES = 1024,
  parameter int TIMEOUT    = 4096
)(
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         int_valid,
  input  logic [PREFIX_W-1:0]          int_prefix,
  input  logic [LEN_W-1:0]             int_len,
  input  logic [$clog2(NUM_FACES)-1:0] int_face,
  output logic                         int_ready,
  output logic                         int_drop,
  output logic                         fib_req,
  output logic [PREFIX_W-1:0]          fib_req_prefix,
  output logic [LEN_W-1:0]             fib_req_len,
  input  logic                         fib_prefix_ready,
  input  logic [PREFIX_W-1:0]          fib_prefix_in,
  input  logic [LEN_W-1:0]             fib_len_in,
  input  logic [7:0]                   fib_data_in,
  output logic                         fib_reject,
  output logic                         fib_start_send,
  output logic [7:0]                   data_out,
  output logic                         data_out_valid,
  output logic                         data_out_last,
  output logic [NUM_FACES-1:0]         data_out_faces
`ifdef PIT_TIMEOUT_EN
  ,
  output logic                         pit_expire
`endif
);

  localparam int IDX_W  = $clog2(ENTRIES);
  localparam int FACE_W = $clog2(NUM_FACES);
  localparam int CNT_W  = $clog2(DATA_BYTES);

  pit_state_t           r_state, w_next;
  pit_entry_t           r_entries [ENTRIES];
  logic [NUM_FACES-1:0] r_faces   [ENTRIES];
  logic [PREFIX_W-1:0]  r_prefix;
  logic [LEN_W-1:0]     r_len;
  logic [FACE_W-1:0]    r_face;
  logic                 r_hit, r_free;
  logic [IDX_W-1:0]     r_hit_idx, r_free_idx;
  logic [CNT_W-1:0]     r_cnt;
  logic [7:0]           r_data_out;
  logic                 r_data_out_valid, r_data_out_last;
  logic [NUM_FACES-1:0] r_data_out_faces;
  logic                 w_hit, w_free;
  logic [IDX_W-1:0]     w_hit_idx, w_free_idx;
  logic [NUM_FACES-1:0] w_face_bit;
  logic [ENTRIES-1:0]   w_expire;

  assign w_face_bit = NUM_FACES'(1) << r_face;

  pit_match #(.ENTRIES(ENTRIES)) u_match (
    .prefix   (r_prefix),
    .len      (r_len),
    .entries  (r_entries),
    .hit      (w_hit),
    .hit_idx  (w_hit_idx),
    .free     (w_free),
    .free_idx (w_free_idx)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (fib_prefix_ready) w_next = ST_D_LOOKUP;
        else if (int_valid)   w_next = ST_I_LOOKUP;
      end
      ST_I_LOOKUP: w_next = ST_I_UPDATE;
      ST_I_UPDATE: w_next = ST_IDLE;
      ST_D_LOOKUP: w_next = ST_D_RESP;
      ST_D_RESP:   w_next = r_hit ? ST_RECEIVE : ST_IDLE;
      // Leave one cycle after the last byte so data_out_last is presented.
      ST_RECEIVE:  if (r_data_out_last) w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    int_ready      = (r_state == ST_IDLE) && !fib_prefix_ready && !rst;
    int_drop       = (r_state == ST_I_UPDATE) && !r_hit && !r_free;
    fib_req        = (r_state == ST_I_UPDATE) && !r_hit && r_free;
    fib_start_send = (r_state == ST_D_RESP) && r_hit;
    fib_reject     = (r_state == ST_D_RESP) && !r_hit;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_entries[i] <= '0;
        r_faces[i]   <= '0;
      end
      r_prefix         <= '0;
      r_len            <= '0;
      r_face           <= '0;
      r_hit            <= 1'b0;
      r_free           <= 1'b0;
      r_hit_idx        <= '0;
      r_free_idx       <= '0;
      r_cnt            <= '0;
      r_data_out       <= '0;
      r_data_out_valid <= 1'b0;
      r_data_out_last  <= 1'b0;
      r_data_out_faces <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (fib_prefix_ready) begin
            r_prefix <= fib_prefix_in;
            r_len    <= fib_len_in;
          end else if (int_valid) begin
            r_prefix <= int_prefix;
            r_len    <= int_len;
            r_face   <= int_face;
          end
        end
        ST_I_LOOKUP, ST_D_LOOKUP: begin
          r_hit      <= w_hit;
          r_hit_idx  <= w_hit_idx;
          r_free     <= w_free;
          r_free_idx <= w_free_idx;
        end
        ST_I_UPDATE: begin
          if (r_hit) begin
            r_faces[r_hit_idx] <= r_faces[r_hit_idx] | w_face_bit;
          end else if (r_free) begin
            r_entries[r_free_idx] <= '{valid: 1'b1, prefix: r_prefix, len: r_len};
            r_faces[r_free_idx]   <= w_face_bit;
          end
        end
        ST_D_RESP: begin
          if (r_hit) begin
            r_data_out_faces <= r_faces[r_hit_idx];
            r_cnt            <= '0;
          end
        end
        ST_RECEIVE: begin
          if (r_data_out_last) begin
            r_data_out_valid             <= 1'b0;
            r_data_out_last              <= 1'b0;
            r_entries[r_hit_idx].valid   <= 1'b0;
          end else begin
            r_data_out       <= fib_data_in;
            r_data_out_valid <= 1'b1;
            r_data_out_last  <= (r_cnt == CNT_W'(DATA_BYTES - 1));
            r_cnt            <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
      for (int i = 0; i < ENTRIES; i++) begin
        if (w_expire[i]) r_entries[i].valid <= 1'b0;
      end
    end
  end

`ifdef PIT_TIMEOUT_EN
  localparam int AGE_W = $clog2(TIMEOUT + 1);

  logic [AGE_W-1:0] r_age [ENTRIES];
  logic             w_lock_en;
  logic [IDX_W-1:0] w_lock_idx;

  // The entry under lookup or transfer must survive until the FSM is done with it.
  always_comb begin
    w_lock_en  = 1'b0;
    w_lock_idx = '0;
    case (r_state)
      ST_I_LOOKUP, ST_D_LOOKUP: begin
        w_lock_en  = w_hit;
        w_lock_idx = w_hit_idx;
      end
      ST_I_UPDATE, ST_D_RESP, ST_RECEIVE: begin
        w_lock_en  = r_hit;
        w_lock_idx = r_hit_idx;
      end
      default: ;
    endcase
  end

  for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_age
    logic w_touch;
    assign w_touch = (r_state == ST_I_UPDATE) &&
                     (r_hit ? (r_hit_idx == IDX_W'(gi)) : (r_free && r_free_idx == IDX_W'(gi)));
    assign w_expire[gi] = r_entries[gi].valid && (r_age[gi] == AGE_W'(TIMEOUT)) &&
                          !(w_lock_en && (w_lock_idx == IDX_W'(gi)));
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                  r_age[gi] <= '0;
      else if (w_touch)         r_age[gi] <= '0;
      else if (r_entries[gi].valid && r_age[gi] != AGE_W'(TIMEOUT))
                                r_age[gi] <= r_age[gi] + 1'b1;
    end
  end

  assign pit_expire = |w_expire;
`else
  assign w_expire = '0;
`endif

  assign fib_req_prefix = r_prefix;
  assign fib_req_len    = r_len;
  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;
  assign data_out_last  = r_data_out_last;
  assign data_out_faces = r_data_out_faces;

endmodule
`default_nettype wire

// File: doc/pit_table.md
# pit_table

Pending Interest Table for the NDN router. It records outstanding interests per prefix and face, aggregates duplicate interests, and issues forwarding requests toward the FIB. On the data return path it answers the FIB's prefix query with accept or reject, then receives the data payload and forwards it to every requesting face. It sits between the interface/face logic and the FIB, and is the responder end of the FIB→PIT prefix-check and data-transfer handshake.

## Interface
- ENTRIES, 16, number of PIT entries
- NUM_FACES, 4, number of faces; one bit per face in masks
- DATA_BYTES, 1024, payload bytes per data packet
- TIMEOUT, 4096, entry lifetime in cycles (used only with PIT_TIMEOUT_EN)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- int_valid  in  1  interest present
- int_prefix  in  64  interest prefix
- int_len  in  6  interest prefix length
- int_face  in  $clog2(NUM_FACES)  arrival face
- int_ready  out  1  PIT can accept an interest this cycle
- int_drop  out  1  1-cycle pulse: interest dropped, table full
- fib_req  out  1  1-cycle pulse: forward new interest to FIB
- fib_req_prefix  out  64  prefix for fib_req
- fib_req_len  out  6  length for fib_req
- fib_prefix_ready  in  1  1-cycle pulse: FIB presents a data prefix
- fib_prefix_in  in  64  data prefix, valid with fib_prefix_ready
- fib_len_in  in  6  data prefix length
- fib_data_in  in  8  payload byte stream from FIB
- fib_reject  out  1  1-cycle pulse: prefix not pending
- fib_start_send  out  1  1-cycle pulse: prefix pending, send payload
- data_out  out  8  payload byte to faces
- data_out_valid  out  1  data_out valid
- data_out_last  out  1  final payload byte
- data_out_faces  out  NUM_FACES  destination face mask, stable for the whole packet
- pit_expire  out  1  1-cycle pulse: an entry timed out (present only with PIT_TIMEOUT_EN)

## Operation
- Each entry holds: valid, prefix[63:0], len[5:0], faces[NUM_FACES-1:0]. An entry matches when it is valid and both prefix and len are exactly equal.
- FSM states: IDLE, I_LOOKUP, I_UPDATE, D_LOOKUP, D_RESP, RECEIVE.
- IDLE:
  - fib_prefix_ready has priority. Latch the prefix and len, then go to D_LOOKUP.
  - Otherwise, int_ready=1. On int_valid, latch prefix, len and face, then go to I_LOOKUP.
  - int_ready=0 in every other state and in any cycle where fib_prefix_ready=1.
- I_LOOKUP: register the match result (hit, hit_idx, free, free_idx = lowest-index invalid entry), then go to I_UPDATE.
- I_UPDATE:
  - Hit: OR the face bit into the entry's faces; no fib_req.
  - Miss with a free entry: allocate that entry and pulse fib_req with the latched prefix and len.
  - Miss with the table full: pulse int_drop.
  - In all cases, return to IDLE.
- D_LOOKUP: register the match result, then go to D_RESP.
- D_RESP:
  - Hit: pulse fib_start_send, latch faces into data_out_faces, clear the byte counter, go to RECEIVE.
  - Miss: pulse fib_reject and go to IDLE.
- RECEIVE:
  - Capture fib_data_in every cycle. data_out is the registered copy, with data_out_valid=1.
  - Counter width is $clog2(DATA_BYTES). The byte at count DATA_BYTES-1 sets data_out_last.
  - On that byte, the matched entry's valid bit clears and the FSM returns to IDLE.
- A fib_prefix_ready pulse outside IDLE is ignored.
- Interest and data paths never operate concurrently.

## Timing
- Reset values: all outputs 0, all entries invalid, FSM in IDLE. int_ready goes to 1 in the first IDLE cycle after reset deasserts.
- Interest accepted at cycle T: fib_req or int_drop at T+2; aggregation takes effect at the edge ending T+2.
- fib_prefix_ready at cycle T: fib_reject or fib_start_send at T+2.
- After fib_start_send at T+2, payload bytes are sampled at T+3 … T+2+DATA_BYTES.
- data_out_valid covers T+4 … T+3+DATA_BYTES. data_out_last is asserted in the final cycle.
- The FSM is back in IDLE at T+4+DATA_BYTES.
- Reset asserted mid-RECEIVE aborts the transfer immediately: outputs go to 0 and all entries are cleared.

## Configuration
- PIT_TIMEOUT_EN defined:
  - Each entry has an age counter of width $clog2(TIMEOUT+1). It is cleared on allocate and on aggregation, and increments each cycle while valid.
  - When age reaches TIMEOUT, the entry invalidates and pit_expire pulses.
  - The entry latched in D_LOOKUP/D_RESP/RECEIVE is locked and does not expire.
  - Several simultaneous expiries produce a single pit_expire pulse.
- PIT_TIMEOUT_EN undefined: there are no age counters and no pit_expire port; entries clear only on data delivery.

## Structure
- Shared package pit_pkg: FSM state enum, the entry struct typedef, and the PREFIX_W=64 and LEN_W=6 constants.
- Sub-module pit_match: parallel comparator across all entries plus a priority encoder. Inputs: prefix, len, entry array. Outputs: hit, hit_idx, free, free_idx.

## Test plan
- Interest 0xA5A5_0000_0000_0001/len 16 on face 0 into an empty table → fib_req at T+2 with the same prefix and len; entry 0 valid, faces=0001.
- Same interest on face 2 → no fib_req; entry 0 faces=0101.
- fib_prefix_ready with that prefix → fib_start_send at T+2. Send bytes 0x00…0xFF repeating, DATA_BYTES=1024 → 1024 data_out_valid cycles, data_out_faces=0101, data_out_last on byte 1023; entry 0 invalid afterward.
- fib_prefix_ready with an unknown prefix 0x1234/len 8 → fib_reject at T+2; no data_out_valid.
- Fill all 16 entries, then send a 17th distinct interest → int_drop at T+2, no fib_req.
- With PIT_TIMEOUT_EN and TIMEOUT=8: allocate an entry and idle → pit_expire after 8 cycles. A later data query for that prefix → fib_reject. Also assert rst at byte 500 of a transfer → outputs 0 and the table is empty.
